// File: rtl/stepper_pkg.sv
// Shared definitions for the dispenser stepper coil bus: phase patterns,
// slot geometry and the move-tracking FSM encoding.
package stepper_pkg;

  localparam logic [3:0] PH_OFF = 4'b0000;
  localparam logic [3:0] PH_A   = 4'b1000;
  localparam logic [3:0] PH_B   = 4'b0100;
  localparam logic [3:0] PH_C   = 4'b0010;
  localparam logic [3:0] PH_D   = 4'b0001;

  localparam int STEPS_PER_SLOT = 512;
  localparam int NUM_SLOTS      = 4;
  localparam int STEPS_PER_REV  = STEPS_PER_SLOT * NUM_SLOTS;
  localparam int POS_W          = $clog2(STEPS_PER_REV);
  localparam int SLOT_SHIFT     = $clog2(STEPS_PER_SLOT);

  typedef enum logic {
    IDLE   = 1'b0,
    MOVING = 1'b1
  } move_state_t;

  // Successor of an illegal pattern is 1111, which can never match a legal cur.
  function automatic logic [3:0] next_phase(input logic [3:0] p);
    logic [3:0] n;
    case (p)
      PH_OFF:  n = PH_A;
      PH_A:    n = PH_B;
      PH_B:    n = PH_C;
      PH_C:    n = PH_D;
      PH_D:    n = PH_A;
      default: n = 4'b1111;
    endcase
    return n;
  endfunction

  function automatic logic is_legal(input logic [3:0] p);
    logic ok;
    case (p)
      PH_OFF, PH_A, PH_B, PH_C, PH_D: ok = 1'b1;
      default:                        ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/coil_sync.sv
// Multi-stage synchronizer for the asynchronous coil bus; all stages clear
// to zero on reset so a released reset never fabricates a phase change.
module coil_sync #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/stepper_phase_monitor.sv
// Receive-side decoder for the stepper coil bus: validates the phase sequence,
// tracks absolute position and reports the compartment reached once motion settles.
module stepper_phase_monitor
  import stepper_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1000000,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           coil_in,
  input  logic                 clear_err,
  output logic                 step_pulse,
  output logic [POS_W-1:0]     step_count,
  output logic [POS_W-1:0]     move_steps,
  output logic [NUM_SLOTS-1:0] slot_onehot,
  output logic                 moving,
  output logic                 arrived,
  output logic                 err_illegal,
  output logic                 err_skip,
  output logic                 err_misalign
);

  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SETTLE_W-1:0] SETTLE_MAX = SETTLE_W'(SETTLE_CYCLES - 1);

  logic [3:0]           cur;
  logic [3:0]           prev;
  logic                 changed;
  logic                 step_ok;
  logic                 skip_hit;
  logic                 illegal_hit;
  logic [POS_W-1:0]     move_cnt;
  logic [SETTLE_W-1:0]  settle_cnt;
  logic                 start_move;
  logic                 settle_done;
  logic                 aligned;
  logic [NUM_SLOTS-1:0] slot_code;
  move_state_t          state_q;
  move_state_t          state_d;

  coil_sync #(
    .STAGES(SYNC_STAGES),
    .WIDTH (4)
  ) u_coil_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (coil_in),
    .q    (cur)
  );

  assign changed = (cur != prev);

  // An illegal prev has no successor, so anything but de-energise after it is a skip.
  always_comb begin
    step_ok     = 1'b0;
    skip_hit    = 1'b0;
    illegal_hit = 1'b0;
    if (changed) begin
      if (!is_legal(cur)) begin
        illegal_hit = 1'b1;
      end else if (cur == next_phase(prev)) begin
        step_ok = 1'b1;
      end else if (cur != PH_OFF) begin
        skip_hit = 1'b1;
      end
    end
  end

  assign aligned = (step_count[SLOT_SHIFT-1:0] == '0);

  always_comb begin
    slot_code = '0;
    slot_code[step_count[POS_W-1:SLOT_SHIFT]] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Settling only completes on a quiet cycle, so a step landing on expiry keeps the move open.
  always_comb begin
    state_d     = state_q;
    start_move  = 1'b0;
    settle_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (step_ok) begin
          state_d    = MOVING;
          start_move = 1'b1;
        end
      end
      MOVING: begin
        if (!changed && settle_cnt == SETTLE_MAX) begin
          state_d     = IDLE;
          settle_done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev         <= PH_OFF;
      step_pulse   <= 1'b0;
      step_count   <= '0;
      move_cnt     <= '0;
      move_steps   <= '0;
      settle_cnt   <= '0;
      slot_onehot  <= NUM_SLOTS'(1);
      moving       <= 1'b0;
      arrived      <= 1'b0;
      err_illegal  <= 1'b0;
      err_skip     <= 1'b0;
      err_misalign <= 1'b0;
    end else begin
      prev       <= cur;
      step_pulse <= step_ok;
      arrived    <= settle_done;
      moving     <= (state_d == MOVING);

      if (step_ok) begin
        step_count <= step_count + 1'b1;
      end

      if (start_move) begin
        move_cnt <= POS_W'(1);
      end else if (step_ok && move_cnt != '1) begin
        move_cnt <= move_cnt + 1'b1;
      end

      if (changed || state_q == IDLE || settle_done) begin
        settle_cnt <= '0;
      end else begin
        settle_cnt <= settle_cnt + 1'b1;
      end

      if (settle_done) begin
        move_steps  <= move_cnt;
        slot_onehot <= aligned ? slot_code : '0;
      end

      // New errors take priority over a coincident clear.
      if (illegal_hit) begin
        err_illegal <= 1'b1;
      end else if (clear_err) begin
        err_illegal <= 1'b0;
      end

      if (skip_hit) begin
        err_skip <= 1'b1;
      end else if (clear_err) begin
        err_skip <= 1'b0;
      end

      if (settle_done && !aligned) begin
        err_misalign <= 1'b1;
      end else if (clear_err) begin
        err_misalign <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stepper_phase_monitor.sv
// Self-checking bench for stepper_phase_monitor: directed vector table, corner-case
// sequences and a randomized run against a pattern-level reference model.
module tb_stepper_phase_monitor;

  localparam int SETTLE = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  coil_in = 4'b0000;
  logic        clear_err = 1'b0;
  logic        step_pulse;
  logic [10:0] step_count;
  logic [10:0] move_steps;
  logic [3:0]  slot_onehot;
  logic        moving;
  logic        arrived;
  logic        err_illegal;
  logic        err_skip;
  logic        err_misalign;

  int compared = 0;
  int mismatched = 0;

  int cyc = 0;
  int pulse_cnt = 0;
  int arr_cnt = 0;
  int last_pulse_cyc = 0;
  int last_arr_cyc = 0;

  typedef struct {
    logic [3:0] pat;
    int         pulse;
    int         skip;
    int         ill;
    int         count;
  } vec_t;

  vec_t vecs[12];

  logic [3:0] m_last;
  int m_count, m_movecnt, m_movesteps, m_slot;
  int m_skip, m_ill, m_mis, m_inmove, m_pulses, m_arrivals;

  stepper_phase_monitor #(
    .SETTLE_CYCLES(SETTLE),
    .SYNC_STAGES  (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .coil_in     (coil_in),
    .clear_err   (clear_err),
    .step_pulse  (step_pulse),
    .step_count  (step_count),
    .move_steps  (move_steps),
    .slot_onehot (slot_onehot),
    .moving      (moving),
    .arrived     (arrived),
    .err_illegal (err_illegal),
    .err_skip    (err_skip),
    .err_misalign(err_misalign)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (step_pulse) begin
        pulse_cnt++;
        last_pulse_cyc = cyc;
      end
      if (arrived) begin
        arr_cnt++;
        last_arr_cyc = cyc;
      end
    end
  end

  task automatic check(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    coil_in = 4'b0000;
    clear_err = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic drive(input logic [3:0] p, input int gap);
    coil_in = p;
    tick(gap);
  endtask

  function automatic logic [3:0] phase_at(input int i);
    case (i % 4)
      0:       return 4'b1000;
      1:       return 4'b0100;
      2:       return 4'b0010;
      default: return 4'b0001;
    endcase
  endfunction

  task automatic run_steps(input int n, input int gap);
    for (int i = 0; i < n; i++) drive(phase_at(i), gap);
  endtask

  // Forward successor of a pattern, or -1 when the pattern has none (illegal).
  function automatic int model_succ(input logic [3:0] p);
    if (p == 4'b0000) return 8;
    for (int i = 0; i < 4; i++) begin
      if (phase_at(i) == p) return int'(phase_at(i + 1));
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_last = 4'b0000;
    m_count = 0; m_movecnt = 0; m_movesteps = 0; m_slot = 1;
    m_skip = 0; m_ill = 0; m_mis = 0; m_inmove = 0;
    m_pulses = pulse_cnt; m_arrivals = arr_cnt;
  endtask

  task automatic model_apply(input logic [3:0] p, input int gap);
    if (p != m_last) begin
      if ($countones(p) > 1) begin
        m_ill = 1;
      end else if (model_succ(m_last) == int'(p)) begin
        m_count = (m_count + 1) % 2048;
        m_pulses++;
        if (!m_inmove) begin
          m_inmove = 1;
          m_movecnt = 1;
        end else if (m_movecnt < 2047) begin
          m_movecnt++;
        end
      end else if (p != 4'b0000) begin
        m_skip = 1;
      end
      m_last = p;
    end
    if (gap >= 25 && m_inmove) begin
      m_arrivals++;
      m_movesteps = m_movecnt;
      m_inmove = 0;
      if (m_count % 512 == 0) begin
        m_slot = 1 << (m_count / 512);
      end else begin
        m_slot = 0;
        m_mis = 1;
      end
    end
  endtask

  task automatic check_model();
    check("rnd_count", int'(step_count), m_count);
    check("rnd_pulses", pulse_cnt, m_pulses);
    check("rnd_arrivals", arr_cnt, m_arrivals);
    check("rnd_moving", int'(moving), m_inmove);
    check("rnd_skip", int'(err_skip), m_skip);
    check("rnd_illegal", int'(err_illegal), m_ill);
    check("rnd_misalign", int'(err_misalign), m_mis);
    check("rnd_slot", int'(slot_onehot), m_slot);
    check("rnd_move_steps", int'(move_steps), m_movesteps);
  endtask

  initial begin
    int base_p, base_a, lat, gap, r;
    logic [3:0] p;

    vecs[0]  = '{4'b1000, 1, 0, 0, 1};
    vecs[1]  = '{4'b0100, 1, 0, 0, 2};
    vecs[2]  = '{4'b0010, 1, 0, 0, 3};
    vecs[3]  = '{4'b0001, 1, 0, 0, 4};
    vecs[4]  = '{4'b1000, 1, 0, 0, 5};
    vecs[5]  = '{4'b0000, 0, 0, 0, 5};
    vecs[6]  = '{4'b1000, 1, 0, 0, 6};
    vecs[7]  = '{4'b0010, 0, 1, 0, 6};
    vecs[8]  = '{4'b0100, 0, 1, 0, 6};
    vecs[9]  = '{4'b1100, 0, 1, 1, 6};
    vecs[10] = '{4'b0010, 0, 1, 1, 6};
    vecs[11] = '{4'b0001, 1, 1, 1, 7};

    // Reset state and vector table
    do_reset();
    check("rst_step_count", int'(step_count), 0);
    check("rst_slot", int'(slot_onehot), 1);
    check("rst_moving", int'(moving), 0);
    check("rst_move_steps", int'(move_steps), 0);
    check("rst_errors", int'({err_illegal, err_skip, err_misalign}), 0);
    for (int i = 0; i < 12; i++) begin
      base_p = pulse_cnt;
      drive(vecs[i].pat, 8);
      check($sformatf("vec%0d_pulse", i), pulse_cnt - base_p, vecs[i].pulse);
      check($sformatf("vec%0d_count", i), int'(step_count), vecs[i].count);
      check($sformatf("vec%0d_skip", i), int'(err_skip), vecs[i].skip);
      check($sformatf("vec%0d_illegal", i), int'(err_illegal), vecs[i].ill);
    end

    // Three spaced steps and sync latency
    do_reset();
    base_p = pulse_cnt;
    coil_in = 4'b1000;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      if (step_pulse) begin
        lat = i;
        break;
      end
    end
    check("latency", lat, 3);
    tick(20 - lat);
    drive(4'b0100, 20);
    drive(4'b0010, 6);
    check("t1_pulses", pulse_cnt - base_p, 3);
    check("t1_count", int'(step_count), 3);
    check("t1_moving", int'(moving), 1);
    check("t1_errors", int'({err_illegal, err_skip}), 0);

    // Full move to slot 1
    do_reset();
    base_a = arr_cnt;
    run_steps(512, 4);
    tick(40);
    check("t2_arrivals", arr_cnt - base_a, 1);
    check("t2_delay_ok", int'((last_arr_cyc - last_pulse_cyc) inside {[15:18]}), 1);
    check("t2_move_steps", int'(move_steps), 512);
    check("t2_slot", int'(slot_onehot), 2);
    check("t2_misalign", int'(err_misalign), 0);
    check("t2_moving", int'(moving), 0);

    // Full revolution wraps home; move length saturates
    do_reset();
    run_steps(2048, 4);
    tick(40);
    check("t3_count", int'(step_count), 0);
    check("t3_slot", int'(slot_onehot), 1);
    check("t3_move_steps", int'(move_steps), 2047);
    check("t3_misalign", int'(err_misalign), 0);

    // Error flags, clear priority
    do_reset();
    drive(4'b1000, 8);
    drive(4'b0010, 8);
    check("t4_skip", int'(err_skip), 1);
    check("t4_skip_count", int'(step_count), 1);
    drive(4'b1100, 8);
    check("t4_illegal", int'(err_illegal), 1);
    coil_in = 4'b0001;
    tick(2);
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
    tick(4);
    check("t4_skip_wins_clear", int'(err_skip), 1);
    check("t4_illegal_cleared", int'(err_illegal), 0);
    drive(4'b1110, 8);
    check("t4_illegal_again", int'(err_illegal), 1);
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
    tick(1);
    check("t4_lone_clear", int'({err_illegal, err_skip}), 0);

    // Misaligned stop
    do_reset();
    base_a = arr_cnt;
    run_steps(100, 4);
    tick(40);
    check("t5_arrivals", arr_cnt - base_a, 1);
    check("t5_slot", int'(slot_onehot), 0);
    check("t5_misalign", int'(err_misalign), 1);
    check("t5_move_steps", int'(move_steps), 100);

    // Asynchronous reset mid-move
    do_reset();
    run_steps(200, 4);
    check("t6_premoving", int'(moving), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_count", int'(step_count), 0);
    check("t6_async_slot", int'(slot_onehot), 1);
    check("t6_async_flags", int'({moving, step_pulse, arrived}), 0);
    check("t6_async_move_steps", int'(move_steps), 0);
    coil_in = 4'b0000;
    tick(3);
    rst_n = 1'b1;
    base_a = arr_cnt;
    tick(40);
    check("t6_no_arrival", arr_cnt - base_a, 0);
    check("t6_count_after", int'(step_count), 0);
    check("t6_slot_after", int'(slot_onehot), 1);

    // Randomized patterns against the reference model
    do_reset();
    model_reset();
    for (int n = 0; n < 250; n++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 5) begin
        p = (model_succ(m_last) < 0) ? 4'b1000 : 4'(model_succ(m_last));
      end else if (r == 6) begin
        p = 4'b0000;
      end else begin
        p = 4'($urandom_range(0, 15));
      end
      if (p == m_last) p = p ^ 4'b0001;
      gap = ($urandom_range(0, 7) == 0) ? 30 : int'($urandom_range(5, 10));
      model_apply(p, gap);
      drive(p, gap);
      check_model();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
